// File: rtl/r2r_pkg.sv
// Shared types and constants for the R2R ladder ADC controller.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package r2r_pkg;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DONE
  } state_t;

  // Conversion algorithm selected when a conversion is accepted.
  typedef enum logic {
    MODE_SAR,
    MODE_RAMP
  } conv_mode_t;

  // Native width of the R2R ladder.
  localparam int R2R_BITS = 8;

endpackage

// File: rtl/r2r_adc_controller_sync_ff.sv
// Multi-flop synchronizer for a single asynchronous input pin.
// Latency: STAGES clock cycles from pin to q.
// Backpressure: none; samples every cycle.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous pin through the flop chain; stage 0 may go metastable.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/r2r_adc_controller.sv
// R2R ladder ADC controller: SAR or ramp conversion against an external comparator.
// Latency: SAR 1+DATA_BITS*SETTLE_CYCLES cycles from accept; ramp 1+(k_stop+1)*SETTLE_CYCLES.
// Backpressure: none; start is ignored (not queued) while a conversion is in flight.
module r2r_adc_controller
  import r2r_pkg::*;
#(
  parameter int DATA_BITS     = R2R_BITS,
  parameter int SETTLE_CYCLES = 64,
  parameter int SYNC_STAGES   = 2,
  parameter int FREE_RUN      = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mode,
  input  logic                 comp_in,
  output logic [DATA_BITS-1:0] r2r_code,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 busy
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0]     CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [BIT_W-1:0]     BIT_MSB    = BIT_W'(DATA_BITS - 1);
  localparam logic [DATA_BITS-1:0] CODE_MSB   = DATA_BITS'(1) << (DATA_BITS - 1);
  localparam logic [DATA_BITS-1:0] CODE_MAX   = '1;

  state_t                 state_q, state_d;
  conv_mode_t             mode_q, mode_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0]   code_q, code_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic [DATA_BITS-1:0]   trial;
  logic                   comp_s;

  // The comparator is asynchronous to clk; only its synchronized copy is used.
  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_comp_sync (
    .clk   (clk),
    .reset (reset),
    .d     (comp_in),
    .q     (comp_s)
  );

  // Register all controller state; reset aborts any conversion in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_SAR;
      cnt_q   <= '0;
      bit_q   <= '0;
      code_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      code_q  <= code_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic: accept, hold each code for SETTLE_CYCLES, then decide.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    code_d  = code_q;
    data_d  = data_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    trial   = code_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start || (FREE_RUN != 0)) begin
          mode_d  = conv_mode_t'(mode);
          state_d = SETTLE;
          cnt_d   = CNT_RELOAD;
          bit_d   = BIT_MSB;
          busy_d  = 1'b1;
          code_d  = (conv_mode_t'(mode) == MODE_RAMP) ? '0 : CODE_MSB;
        end
      end

      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (mode_q == MODE_SAR) begin
          // Comparator low means the trial code overshot Vin: drop the bit under test.
          if (!comp_s) begin
            trial[bit_q] = 1'b0;
          end
          if (bit_q != '0) begin
            trial[bit_q - BIT_W'(1)] = 1'b1;
            bit_d  = bit_q - BIT_W'(1);
            cnt_d  = CNT_RELOAD;
            code_d = trial;
          end else begin
            code_d  = trial;
            data_d  = trial;
            valid_d = 1'b1;
            state_d = DONE;
          end
        end else begin
          // Ramp stops at the first code that exceeds Vin, or saturates at full scale.
          if (!comp_s) begin
            trial   = (code_q == '0) ? '0 : code_q - DATA_BITS'(1);
            code_d  = trial;
            data_d  = trial;
            valid_d = 1'b1;
            state_d = DONE;
          end else if (code_q == CODE_MAX) begin
            data_d  = code_q;
            valid_d = 1'b1;
            state_d = DONE;
          end else begin
            code_d = code_q + DATA_BITS'(1);
            cnt_d  = CNT_RELOAD;
          end
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign r2r_code   = code_q;
  assign data       = data_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_r2r_adc_controller.sv
// Self-checking bench for r2r_adc_controller with SETTLE_CYCLES=4.
// Latency: SAR result due 33 cycles after the start cycle; ramp 1+(k_stop+1)*4.
// Backpressure: none; a second instance exercises free-run restart.
module tb_r2r_adc_controller;
  import r2r_pkg::*;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] vin = 8'h00;
  logic [7:0] vin_fr = 8'h00;
  logic       force_low = 1'b0;

  logic       comp_in, fr_comp;
  logic [7:0] r2r_code, data, fr_code, fr_data;
  logic       data_valid, busy, fr_valid, fr_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] dat;
    int         due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Comparator model: high while Vin >= Vdac; force_low emulates Vin below ground.
  assign comp_in = force_low ? 1'b0 : (vin >= r2r_code);
  assign fr_comp = (vin_fr >= fr_code);

  r2r_adc_controller #(
    .DATA_BITS(8), .SETTLE_CYCLES(S), .SYNC_STAGES(2), .FREE_RUN(0)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .comp_in(comp_in),
    .r2r_code(r2r_code), .data(data), .data_valid(data_valid), .busy(busy)
  );

  r2r_adc_controller #(
    .DATA_BITS(8), .SETTLE_CYCLES(S), .SYNC_STAGES(2), .FREE_RUN(1)
  ) dut_fr (
    .clk(clk), .reset(reset), .start(1'b0), .mode(1'b0), .comp_in(fr_comp),
    .r2r_code(fr_code), .data(fr_data), .data_valid(fr_valid), .busy(fr_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Scoreboard: every strobe must match the oldest expected result and its due cycle.
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got data=%h at cycle %0d, required no strobe", data, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (data !== mon_e.dat || cyc != mon_e.due) begin
          errors++;
          $display("FAIL scoreboard: got data=%h at cycle %0d, required data=%h at cycle %0d",
                   data, cyc, mon_e.dat, mon_e.due);
        end
      end
    end
  end

  task automatic start_conv(input logic m, input logic [7:0] exp_dat, input int lat,
                            input bit expect_out, output int t);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    t     = cyc;
    if (expect_out) sb.push_back('{dat: exp_dat, due: t + lat});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input int budget, output bit ok);
    ok = 1'b0;
    repeat (budget) begin
      @(posedge clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({r2r_code, data, data_valid, busy} !== 18'h0) begin
      errors++;
      $display("FAIL reset_main: got code=%h data=%h valid=%b busy=%b, required all zero",
               r2r_code, data, data_valid, busy);
    end
    checks++;
    if ({fr_code, fr_data, fr_valid, fr_busy} !== 18'h0) begin
      errors++;
      $display("FAIL reset_free_run: got code=%h data=%h valid=%b busy=%b, required all zero",
               fr_code, fr_data, fr_valid, fr_busy);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_sar;
    logic [7:0] seq [8];
    int t;
    bit ok;
    seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    vin = 8'hA5;
    start_conv(MODE_SAR, 8'hA5, 33, 1'b1, t);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL sar_busy_accept: got busy=%b, required 1", busy);
    end
    for (int j = 0; j < 8; j++) begin
      wait_cyc(t + 1 + S * j);
      checks++;
      if (r2r_code !== seq[j]) begin
        errors++;
        $display("FAIL sar_code_step%0d: got %h, required %h", j, r2r_code, seq[j]);
      end
    end
    wait_cyc(t + 33);
    checks++;
    if (busy !== 1'b1 || r2r_code !== 8'hA5) begin
      errors++;
      $display("FAIL sar_done_cycle: got busy=%b code=%h, required busy=1 code=a5", busy, r2r_code);
    end
    wait_cyc(t + 34);
    checks++;
    if (busy !== 1'b0 || data !== 8'hA5 || data_valid !== 1'b0) begin
      errors++;
      $display("FAIL sar_post_done: got busy=%b data=%h valid=%b, required 0/a5/0",
               busy, data, data_valid);
    end
    drain(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL sar_drain: got %0d outstanding results, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_ramp;
    int t;
    bit ok;
    vin = 8'h03;
    start_conv(MODE_RAMP, 8'h03, 21, 1'b1, t);
    for (int j = 0; j < 5; j++) begin
      wait_cyc(t + 1 + S * j);
      checks++;
      if (r2r_code !== 8'(j)) begin
        errors++;
        $display("FAIL ramp_code_step%0d: got %h, required %h", j, r2r_code, 8'(j));
      end
    end
    drain(40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ramp3_drain: got %0d outstanding results, required 0", sb.size());
      sb.delete();
    end
    vin = 8'hFF;
    start_conv(MODE_RAMP, 8'hFF, 1 + 256 * S, 1'b1, t);
    drain(1100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rampff_drain: got %0d outstanding results, required 0", sb.size());
      sb.delete();
    end
    checks++;
    if (r2r_code !== 8'hFF || data !== 8'hFF) begin
      errors++;
      $display("FAIL rampff_no_wrap: got code=%h data=%h, required ff/ff", r2r_code, data);
    end
  endtask

  task automatic test_zero;
    int t;
    bit ok;
    vin = 8'h00;
    start_conv(MODE_SAR, 8'h00, 33, 1'b1, t);
    drain(50, ok);
    checks++;
    if (!ok || r2r_code !== 8'h00) begin
      errors++;
      $display("FAIL sar_zero: got outstanding=%0d code=%h, required 0/00", sb.size(), r2r_code);
      sb.delete();
    end
    // With Vin=0 the comparator is still high at code 0, so the ramp stops at code 1.
    start_conv(MODE_RAMP, 8'h00, 1 + 2 * S, 1'b1, t);
    drain(30, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ramp_zero: got %0d outstanding results, required 0", sb.size());
      sb.delete();
    end
    // Comparator low already at code 0: result 0 after a single settle period.
    force_low = 1'b1;
    data_fill_check: begin end
    start_conv(MODE_RAMP, 8'h00, 1 + S, 1'b1, t);
    drain(30, ok);
    force_low = 1'b0;
    checks++;
    if (!ok || r2r_code !== 8'h00) begin
      errors++;
      $display("FAIL ramp_floor: got outstanding=%0d code=%h, required 0/00", sb.size(), r2r_code);
      sb.delete();
    end
  endtask

  task automatic test_back_to_back;
    int t;
    int offs [4];
    bit ok;
    offs = '{3, 10, 20, 32};
    vin = 8'h5C;
    start_conv(MODE_SAR, 8'h5C, 33, 1'b1, t);
    for (int k = 0; k < 4; k++) begin
      wait_cyc(t + offs[k]);
      start = 1'b1;
      mode  = ~mode;
      @(negedge clk);
      start = 1'b0;
    end
    drain(40, ok);
    repeat (40) @(negedge clk);
    checks++;
    if (!ok || data !== 8'h5C) begin
      errors++;
      $display("FAIL ignore_start: got outstanding=%0d data=%h, required 0/5c", sb.size(), data);
      sb.delete();
    end
  endtask

  task automatic test_reset_abort;
    int t;
    bit ok;
    vin = 8'hA5;
    start_conv(MODE_SAR, 8'h00, 0, 1'b0, t);
    wait_cyc(t + 10);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (r2r_code !== 8'h00 || busy !== 1'b0 || data_valid !== 1'b0 || data !== 8'h00) begin
      errors++;
      $display("FAIL reset_abort: got code=%h busy=%b valid=%b data=%h, required 00/0/0/00",
               r2r_code, busy, data_valid, data);
    end
    reset = 1'b0;
    repeat (40) @(negedge clk);
    vin = 8'h3C;
    start_conv(MODE_SAR, 8'h3C, 33, 1'b1, t);
    drain(50, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reset_recover: got %0d outstanding results, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_free_run;
    int r, d1, n, low;
    // The first IDLE cycle after reset is the implied accept; each later accept is the
    // IDLE cycle following DONE, so strobes are 34 cycles apart with busy low once.
    @(negedge clk);
    reset  = 1'b1;
    vin_fr = 8'h40;
    @(negedge clk);
    reset = 1'b0;
    r = cyc;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fr_valid !== 1'b1 && n < 100);
    d1 = cyc;
    checks++;
    if (fr_valid !== 1'b1 || fr_data !== 8'h40 || d1 != r + 33) begin
      errors++;
      $display("FAIL free_run_first: got valid=%b data=%h at cycle %0d, required 1/40 at %0d",
               fr_valid, fr_data, d1, r + 33);
    end
    vin_fr = 8'h41;
    n = 0;
    low = 0;
    do begin
      @(negedge clk);
      n++;
      if (fr_busy !== 1'b1) low++;
    end while (fr_valid !== 1'b1 && n < 100);
    checks++;
    if (fr_valid !== 1'b1 || fr_data !== 8'h41 || cyc - d1 != 34) begin
      errors++;
      $display("FAIL free_run_second: got valid=%b data=%h after %0d cycles, required 1/41 after 34",
               fr_valid, fr_data, cyc - d1);
    end
    checks++;
    if (low != 1) begin
      errors++;
      $display("FAIL free_run_busy: got %0d busy-low cycles between strobes, required 1", low);
    end
  endtask

  initial begin
    test_reset();
    test_sar();
    test_ramp();
    test_zero();
    test_back_to_back();
    test_reset_abort();
    test_free_run();
    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d outstanding results, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: simulation still running at time limit, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
